// File: rtl/div_engine.sv
// Reciprocal (program 1) and 16/8 fixed-point divide (program 2) engine using
// restoring division against a byte-wide data memory. Macro DIV_ENGINE_ROUND_EN enables half-LSB rounding.
module div_engine #(
    parameter int P1_BASE = 8,
    parameter int P2_BASE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       prog,
    output logic       done,
    output logic       busy,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic       mem_we,
    output logic [7:0] mem_wdata
);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        LOAD,
        DIVIDE,
        ROUND,
        WRITE,
        DONE
    } state_t;

    localparam logic [7:0] P1_RD = 8'(P1_BASE);
    localparam logic [7:0] P1_WR = 8'(P1_BASE + 2);
    localparam logic [7:0] P2_RD = 8'(P2_BASE);
    localparam logic [7:0] P2_WR = 8'(P2_BASE + 4);

    state_t      state;
    logic        prog_q;
    logic [1:0]  byte_cnt;
    logic [4:0]  bit_cnt;
    logic [15:0] div_in2;
    logic [15:0] divisor;
    logic [15:0] dvd_sr;
    logic [16:0] rem;
    logic [24:0] quo;
    logic [23:0] res_sr;

    logic [17:0] trial;
    logic        fits;
    logic        last_load;
    logic        last_bit;
    logic        last_write;
    logic [15:0] dvs_next;
    logic [23:0] res_load;
    logic [7:0]  wr_base;

    // Result is returned left-aligned in 24 bits so both programs write from [23:16].
    function automatic logic [23:0] round_q(input logic [24:0] q, input logic p2);
        logic [23:0] r;
        logic        inc;
`ifdef DIV_ENGINE_ROUND_EN
        inc = q[0];
`else
        inc = 1'b0;
`endif
        if (p2)
            r = q[24:1] + {23'h0, inc};
        else
            r = {q[16:1] + {15'h0, inc}, 8'h00};
        return r;
    endfunction

    always_comb begin
        trial      = {rem, dvd_sr[15]};
        fits       = (trial >= {2'b00, divisor});
        last_load  = prog_q ? (byte_cnt == 2'd2) : (byte_cnt == 2'd1);
        last_write = prog_q ? (byte_cnt == 2'd2) : (byte_cnt == 2'd1);
        last_bit   = prog_q ? (bit_cnt == 5'd24) : (bit_cnt == 5'd16);
        dvs_next   = prog_q ? {8'h00, mem_rdata} : {divisor[15:8], mem_rdata};
        wr_base    = prog_q ? P2_WR : P1_WR;
        if (state == ROUND)
            res_load = round_q(quo, prog_q);
        else
            res_load = prog_q ? 24'hFF_FFFF : 24'hFF_FF00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            prog_q    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            mem_addr  <= 8'h00;
            mem_we    <= 1'b0;
            mem_wdata <= 8'h00;
            byte_cnt  <= 2'd0;
            bit_cnt   <= 5'd0;
            div_in2   <= 16'h0000;
            divisor   <= 16'h0000;
            dvd_sr    <= 16'h0000;
            rem       <= 17'h0;
            quo       <= 25'h0;
            res_sr    <= 24'h0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= ARMED;
                        done  <= 1'b0;
                    end
                end
                ARMED: begin
                    if (!start) begin
                        prog_q   <= prog;
                        busy     <= 1'b1;
                        state    <= LOAD;
                        byte_cnt <= 2'd0;
                        mem_addr <= prog ? P2_RD : P1_RD;
                        divisor  <= 16'h0000;
                        div_in2  <= 16'h0000;
                    end
                end
                LOAD: begin
                    if (byte_cnt == 2'd0) begin
                        if (prog_q)
                            div_in2[15:8] <= mem_rdata;
                        else
                            divisor[15:8] <= mem_rdata;
                    end else if (prog_q && byte_cnt == 2'd1) begin
                        div_in2[7:0] <= mem_rdata;
                    end
                    if (last_load) begin
                        divisor <= dvs_next;
                        if (dvs_next == 16'h0000) begin
                            // Zero divisor bypasses the divider and writes all-ones.
                            state     <= WRITE;
                            mem_we    <= 1'b1;
                            mem_addr  <= wr_base;
                            mem_wdata <= res_load[23:16];
                            res_sr    <= {res_load[15:0], 8'h00};
                            byte_cnt  <= 2'd0;
                        end else begin
                            state    <= DIVIDE;
                            mem_addr <= 8'h00;
                            rem      <= 17'h0;
                            quo      <= 25'h0;
                            bit_cnt  <= 5'd0;
                            dvd_sr   <= prog_q ? div_in2 : 16'h8000;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + 2'd1;
                        mem_addr <= mem_addr + 8'd1;
                    end
                end
                DIVIDE: begin
                    rem     <= fits ? 17'(trial - {2'b00, divisor}) : trial[16:0];
                    quo     <= {quo[23:0], fits};
                    dvd_sr  <= {dvd_sr[14:0], 1'b0};
                    bit_cnt <= bit_cnt + 5'd1;
                    if (last_bit)
                        state <= ROUND;
                end
                ROUND: begin
                    state     <= WRITE;
                    mem_we    <= 1'b1;
                    mem_addr  <= wr_base;
                    mem_wdata <= res_load[23:16];
                    res_sr    <= {res_load[15:0], 8'h00};
                    byte_cnt  <= 2'd0;
                end
                WRITE: begin
                    if (last_write) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 8'h00;
                        mem_wdata <= 8'h00;
                    end else begin
                        byte_cnt  <= byte_cnt + 2'd1;
                        mem_addr  <= mem_addr + 8'd1;
                        mem_wdata <= res_sr[23:16];
                        res_sr    <= {res_sr[15:0], 8'h00};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_engine.sv
// Scoreboard bench for div_engine: expected results come from native 64-bit division.
module tb_div_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       prog = 1'b0;
    logic       done;
    logic       busy;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] mem [256];
    int total = 0;
    int bad = 0;
    int wr_cnt = 0;

    typedef struct {
        logic        p2;
        logic [23:0] res;
        int          lat;
    } exp_t;
    exp_t sb[$];

`ifdef DIV_ENGINE_ROUND_EN
    localparam logic [15:0] P1_D3_EXP = 16'h2AAB;
`else
    localparam logic [15:0] P1_D3_EXP = 16'h2AAA;
`endif

    div_engine #(.P1_BASE(8), .P2_BASE(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog(prog),
        .done(done), .busy(busy),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model(input logic p2, input logic [15:0] a, input logic [15:0] d);
        logic [63:0] n;
        logic [63:0] q;
        logic        inc;
        if (d == 16'h0000)
            return p2 ? 24'hFF_FFFF : 24'h00_FFFF;
        n = p2 ? {a, 48'h0} : 64'h8000_0000_0000_0000;
        q = n / {48'h0, d};
        inc = 1'b0;
`ifdef DIV_ENGINE_ROUND_EN
        inc = p2 ? q[39] : q[47];
`endif
        if (p2)
            return q[63:40] + {23'h0, inc};
        return {8'h00, q[63:48] + {15'h0, inc}};
    endfunction

    function automatic logic [23:0] read_result(input logic p2);
        if (p2)
            return {mem[4], mem[5], mem[6]};
        return {8'h00, mem[10], mem[11]};
    endfunction

    task automatic load_operands(input logic p2, input logic [15:0] a, input logic [15:0] d);
        if (p2) begin
            mem[0] = a[15:8];
            mem[1] = a[7:0];
            mem[2] = d[7:0];
            mem[4] = 8'h5A; mem[5] = 8'h5A; mem[6] = 8'h5A;
        end else begin
            mem[8] = d[15:8];
            mem[9] = d[7:0];
            mem[10] = 8'h5A; mem[11] = 8'h5A;
        end
    endtask

    task automatic arm_and_fire(input logic p2);
        @(negedge clk);
        start = 1'b1;
        prog  = p2;
        @(negedge clk);
        check("done_clr", {31'h0, done}, 32'h0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        prog = ~p2;
    endtask

    task automatic run_op(input string tag, input logic p2, input logic [15:0] a,
                          input logic [15:0] d, input int exp_lat, input bit glitch);
        exp_t e;
        int   lat;
        int   w0;
        load_operands(p2, a, d);
        e.p2 = p2;
        e.res = model(p2, a, d);
        e.lat = exp_lat;
        sb.push_back(e);
        arm_and_fire(p2);
        check({tag, "_busy"}, {31'h0, busy}, 32'h1);
        w0 = wr_cnt;
        for (lat = 1; lat <= 100; lat++) begin
            @(posedge clk);
            #1;
            if (glitch) start = (lat >= 6 && lat < 9);
            if (done) break;
        end
        e = sb.pop_front();
        check({tag, "_lat"}, lat, e.lat);
        check({tag, "_res"}, {8'h0, read_result(e.p2)}, {8'h0, e.res});
        check({tag, "_nwr"}, wr_cnt - w0, e.p2 ? 3 : 2);
        check({tag, "_busy_end"}, {31'h0, busy}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_hold"}, {31'h0, done}, 32'h1);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_we", {31'h0, mem_we}, 32'h0);
        check("rst_addr", {24'h0, mem_addr}, 32'h0);
        check("rst_wdata", {24'h0, mem_wdata}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("p1_d3", 1'b0, 16'h0000, 16'h0003, 22, 1'b0);
        check("p1_d3_lit", {16'h0, mem[10], mem[11]}, {16'h0, P1_D3_EXP});
        run_op("p1_d1", 1'b0, 16'h0000, 16'h0001, 22, 1'b0);
        check("p1_d1_lit", {16'h0, mem[10], mem[11]}, 32'h8000);
        run_op("p1_d0", 1'b0, 16'h0000, 16'h0000, 4, 1'b0);
        check("p1_d0_lit", {16'h0, mem[10], mem[11]}, 32'hFFFF);
        run_op("p1_dffff", 1'b0, 16'h0000, 16'hFFFF, 22, 1'b0);
        run_op("p2_1_3", 1'b1, 16'h0001, 16'h0003, 32, 1'b0);
        check("p2_1_3_lit", {8'h0, mem[4], mem[5], mem[6]}, 32'h000055);
        run_op("p2_ffff_1", 1'b1, 16'hFFFF, 16'h0001, 32, 1'b1);
        check("p2_ffff_1_lit", {8'h0, mem[4], mem[5], mem[6]}, 32'hFFFF00);
        run_op("p2_d0", 1'b1, 16'h1234, 16'h0000, 6, 1'b0);
        check("p2_d0_lit", {8'h0, mem[4], mem[5], mem[6]}, 32'hFFFFFF);
        for (int k = 0; k < 4; k++) begin
            run_op("p2_rnd", 1'b1, 16'($urandom), 16'($urandom_range(1, 255)), 32, 1'b0);
            run_op("p1_rnd", 1'b0, 16'h0000, 16'($urandom_range(1, 65535)), 22, 1'b0);
        end

        // Abort in the middle of DIVIDE.
        load_operands(1'b0, 16'h0000, 16'h0003);
        arm_and_fire(1'b0);
        w0 = wr_cnt;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_we", {31'h0, mem_we}, 32'h0);
        check("abort_addr", {24'h0, mem_addr}, 32'h0);
        check("abort_wdata", {24'h0, mem_wdata}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("abort_nwr", wr_cnt - w0, 0);
        check("abort_mem", {16'h0, mem[10], mem[11]}, 32'h5A5A);
        check("abort_idle_done", {31'h0, done}, 32'h0);
        check("abort_idle_busy", {31'h0, busy}, 32'h0);
        run_op("after_abort", 1'b0, 16'h0000, 16'h0003, 22, 1'b0);
        check("after_abort_lit", {16'h0, mem[10], mem[11]}, {16'h0, P1_D3_EXP});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
